fetch_unit: RTL and testbench

- Instruction-fetch side of the PIC16C5x core: owns the program counter, the 2-level hardware call stack and the instruction register.
- Consumes the decoder's fetchState phase (Q1..Q4) and drives program ROM address and fetched instruction back to the decoder (instIn) and datapath.
- Applies GOTO/CALL/RETLW/PCL-write/skip redirects issued by the execute stage.
- Implements the two-cycle branch by flushing the already-fetched instruction to NOP.

---
 rtl/fetch_unit_pkg.sv | 18 +
 rtl/fetch_unit_call_stack.sv | 43 ++++
 rtl/fetch_unit.sv | 111 +++++++++++
 tb/tb_fetch_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-side definitions: decoder phase encoding, NOP opcode and
// the baseline instruction width.
package fetch_unit_pkg;

  localparam int unsigned FE_STATE_BITS = 2;
  localparam int unsigned INST_WIDTH    = 12;

  // Decoder fetch phase, one phase per clock, Q1 -> Q2 -> Q3 -> Q4 -> Q1.
  typedef enum logic [FE_STATE_BITS-1:0] {
    FE_Q1_INCPC = 2'b00,
    FE_Q2_IDLE  = 2'b01,
    FE_Q3_IDLE  = 2'b10,
    FE_Q4_FETCH = 2'b11
  } fe_state_e;

  localparam logic [11:0] I_NOP_12 = 12'h000;

endpackage

// File: rtl/fetch_unit_call_stack.sv
// Two-entry hardware return stack. Push shifts the old top down and drops
// the bottom entry; pop copies the bottom entry up and leaves it in place,
// so repeated pops keep returning the last surviving address.
module call_stack #(
  parameter int unsigned PC_WIDTH = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic [PC_WIDTH-1:0] data_i,
  output logic [PC_WIDTH-1:0] top_o
);

  logic [PC_WIDTH-1:0] stack0_q, stack0_d;
  logic [PC_WIDTH-1:0] stack1_q, stack1_d;

  // Next-state: push takes precedence if both strobes ever coincide.
  always_comb begin
    stack0_d = stack0_q;
    stack1_d = stack1_q;
    if (push_i) begin
      stack1_d = stack0_q;
      stack0_d = data_i;
    end else if (pop_i) begin
      stack0_d = stack1_q;
    end
  end

  // Stack registers, cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stack0_q <= '0;
      stack1_q <= '0;
    end else begin
      stack0_q <= stack0_d;
      stack1_q <= stack1_d;
    end
  end

  assign top_o = stack0_q;

endmodule

// File: rtl/fetch_unit.sv
// PIC16C5x instruction fetch: program counter, call stack and instruction
// register. Redirects in Q4 load the PC and flush the fetched word to NOP;
// the following Q1 then skips its increment so the target is fetched next.
module fetch_unit #(
  parameter int unsigned          PC_WIDTH     = 9,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '1,
  parameter int unsigned          INST_WIDTH   = fetch_unit_pkg::INST_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [fetch_unit_pkg::FE_STATE_BITS-1:0] fetchState,
  input  logic [INST_WIDTH-1:0]                  romData,
  input  logic [1:0]                             paBits,
  input  logic                                   gotoEn,
  input  logic                                   callEn,
  input  logic                                   retEn,
  input  logic                                   pclWrEn,
  input  logic [7:0]                             pclWrData,
  input  logic                                   skipEn,
  output logic [PC_WIDTH-1:0]                    romAddr,
  output logic [INST_WIDTH-1:0]                  instOut,
  output logic [PC_WIDTH-1:0]                    pcOut
);

  import fetch_unit_pkg::*;

  localparam logic [INST_WIDTH-1:0] NOP = INST_WIDTH'(I_NOP_12);

  fe_state_e             fe_state;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic                  hold_q, hold_d;
  logic                  push, pop;
  logic [PC_WIDTH-1:0]   stack_top;

  assign fe_state = fe_state_e'(fetchState);

  call_stack #(
    .PC_WIDTH (PC_WIDTH)
  ) u_call_stack (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .pop_i  (pop),
    .data_i (pc_q),
    .top_o  (stack_top)
  );

  // Phase-driven next state. In Q4 the PC already points one past the
  // executing instruction, which is exactly the CALL return address.
  // Targets are built at full 11-bit page width and truncated to PC_WIDTH.
  always_comb begin
    pc_d   = pc_q;
    inst_d = inst_q;
    hold_d = hold_q;
    push   = 1'b0;
    pop    = 1'b0;
    case (fe_state)
      FE_Q1_INCPC: begin
        if (hold_q) hold_d = 1'b0;
        else        pc_d   = pc_q + PC_WIDTH'(1);
      end
      FE_Q4_FETCH: begin
        inst_d = romData;
        if (retEn) begin
          pop    = 1'b1;
          pc_d   = stack_top;
          inst_d = NOP;
          hold_d = 1'b1;
        end else if (callEn) begin
          push   = 1'b1;
          pc_d   = PC_WIDTH'({paBits, 1'b0, inst_q[7:0]});
          inst_d = NOP;
          hold_d = 1'b1;
        end else if (gotoEn) begin
          pc_d   = PC_WIDTH'({paBits, inst_q[8:0]});
          inst_d = NOP;
          hold_d = 1'b1;
        end else if (pclWrEn) begin
          pc_d   = PC_WIDTH'({paBits, 1'b0, pclWrData});
          inst_d = NOP;
          hold_d = 1'b1;
        end else if (skipEn) begin
          inst_d = NOP;
        end
      end
      FE_Q2_IDLE, FE_Q3_IDLE: begin
      end
      default: begin
      end
    endcase
  end

  // PC, instruction register and increment-hold flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= RESET_VECTOR;
      inst_q <= NOP;
      hold_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      inst_q <= inst_d;
      hold_q <= hold_d;
    end
  end

  assign romAddr = pc_q;
  assign pcOut   = pc_q;
  assign instOut = inst_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: acts as decoder (phase sequencer and
// strobe source) and program ROM; expectations go through a scoreboard queue.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [4:0] S_NONE = 5'b00000;
  localparam logic [4:0] S_RET  = 5'b10000;
  localparam logic [4:0] S_CALL = 5'b01000;
  localparam logic [4:0] S_GOTO = 5'b00100;
  localparam logic [4:0] S_PCL  = 5'b00010;
  localparam logic [4:0] S_SKIP = 5'b00001;
  localparam logic [4:0] S_ALL  = 5'b11111;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  fetchState;
  logic [11:0] romData;
  logic [1:0]  paBits;
  logic        gotoEn, callEn, retEn, pclWrEn, skipEn;
  logic [7:0]  pclWrData;
  logic [8:0]  romAddr, pcOut;
  logic [11:0] instOut;

  logic [11:0] rom [0:511];

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  assign romData = rom[romAddr];

  fetch_unit #(
    .PC_WIDTH     (9),
    .RESET_VECTOR (9'h1FF),
    .INST_WIDTH   (12)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fetchState (fetchState),
    .romData    (romData),
    .paBits     (paBits),
    .gotoEn     (gotoEn),
    .callEn     (callEn),
    .retEn      (retEn),
    .pclWrEn    (pclWrEn),
    .pclWrData  (pclWrData),
    .skipEn     (skipEn),
    .romAddr    (romAddr),
    .instOut    (instOut),
    .pcOut      (pcOut)
  );

  task automatic expect_val(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [15:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  // One clock = one decoder phase; outputs sampled 1 time unit after the edge.
  task automatic clk_phase();
    @(posedge clk);
    #1;
    fetchState = fetchState + 2'd1;
  endtask

  // One full instruction cycle Q1..Q4 with strobes presented for Q4 only.
  task automatic icycle(input string tag, input logic [4:0] strb,
                        input logic [8:0] exp_pc, input logic [11:0] exp_inst);
    expect_val({tag, "_pc"},   16'(exp_pc));
    expect_val({tag, "_addr"}, 16'(exp_pc));
    expect_val({tag, "_inst"}, 16'(exp_inst));
    clk_phase();
    clk_phase();
    clk_phase();
    {retEn, callEn, gotoEn, pclWrEn, skipEn} = strb;
    clk_phase();
    {retEn, callEn, gotoEn, pclWrEn, skipEn} = S_NONE;
    check(16'(pcOut));
    check(16'(romAddr));
    check(16'(instOut));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 512; i++) rom[i] = 12'h000;
    rom[9'h1FF] = 12'hA05;
    rom[9'h001] = 12'hA10;  // GOTO 0x010
    rom[9'h010] = 12'h980;  // CALL 0x80
    rom[9'h011] = 12'hA10;  // GOTO 0x010
    rom[9'h081] = 12'h9A0;  // CALL 0xA0
    rom[9'h0A1] = 12'h9C0;  // CALL 0xC0
    rom[9'h083] = 12'h123;  // discarded by skip
    rom[9'h084] = 12'h456;
    rom[9'h034] = 12'hA77;
    rom[9'h035] = 12'h5A5;

    rst        = 1'b1;
    fetchState = 2'b10;
    {retEn, callEn, gotoEn, pclWrEn, skipEn} = S_NONE;
    paBits     = 2'b00;
    pclWrData  = 8'h00;

    #12;
    expect_val("reset_pc", 16'h01FF);
    expect_val("reset_inst", 16'h0000);
    check(16'(pcOut));
    check(16'(instOut));
    @(negedge clk);
    rst = 1'b0;

    // First Q3 then Q4 fetches the reset vector.
    expect_val("first_fetch_pc", 16'h01FF);
    expect_val("first_fetch_inst", 16'h0A05);
    clk_phase();
    clk_phase();
    check(16'(pcOut));
    check(16'(instOut));

    icycle("wrap", S_NONE, 9'h000, 12'h000);
    icycle("seq",  S_NONE, 9'h001, 12'hA10);

    // GOTO 0x010: flush, then held increment and fetch of the target.
    icycle("goto",      S_GOTO, 9'h010, 12'h000);
    icycle("goto_hold", S_NONE, 9'h010, 12'h980);

    // Single CALL/RETLW round trip.
    icycle("call",      S_CALL, 9'h080, 12'h000);
    icycle("call_land", S_NONE, 9'h080, 12'h000);
    icycle("ret",       S_RET,  9'h011, 12'h000);
    icycle("ret_land",  S_NONE, 9'h011, 12'hA10);

    // Three nested calls overflow the two-entry stack.
    icycle("goto2",  S_GOTO, 9'h010, 12'h000);
    icycle("land2",  S_NONE, 9'h010, 12'h980);
    icycle("call1",  S_CALL, 9'h080, 12'h000);
    icycle("c1a",    S_NONE, 9'h080, 12'h000);
    icycle("c1b",    S_NONE, 9'h081, 12'h9A0);
    icycle("call2",  S_CALL, 9'h0A0, 12'h000);
    icycle("c2a",    S_NONE, 9'h0A0, 12'h000);
    icycle("c2b",    S_NONE, 9'h0A1, 12'h9C0);
    icycle("call3",  S_CALL, 9'h0C0, 12'h000);
    icycle("c3a",    S_NONE, 9'h0C0, 12'h000);
    icycle("ret1",   S_RET,  9'h0A2, 12'h000);
    icycle("r1a",    S_NONE, 9'h0A2, 12'h000);
    icycle("ret2",   S_RET,  9'h082, 12'h000);
    icycle("r2a",    S_NONE, 9'h082, 12'h000);
    icycle("ret3",   S_RET,  9'h082, 12'h000);

    // Skip discards the fetched word without holding the increment.
    icycle("pre_skip",  S_NONE, 9'h082, 12'h000);
    icycle("skip",      S_SKIP, 9'h083, 12'h000);
    icycle("skip_next", S_NONE, 9'h084, 12'h456);

    // All strobes at once: RETLW wins (stack top still 0x082).
    icycle("prio", S_ALL, 9'h082, 12'h000);

    // PCL write; page bits fall outside a 9-bit PC.
    icycle("pre_pcl", S_NONE, 9'h082, 12'h000);
    paBits    = 2'b11;
    pclWrData = 8'h34;
    icycle("pcl",      S_PCL,  9'h034, 12'h000);
    icycle("pcl_land", S_NONE, 9'h034, 12'hA77);

    // GOTO strobe in Q2 has no effect.
    expect_val("q2_goto_pc", 16'h0035);
    clk_phase();
    gotoEn = 1'b1;
    clk_phase();
    gotoEn = 1'b0;
    check(16'(pcOut));
    expect_val("q2_goto_inst", 16'h05A5);
    clk_phase();
    clk_phase();
    check(16'(instOut));

    // GOTO uses nine target bits (0x5A5 -> 0x1A5).
    icycle("goto_9bit", S_GOTO, 9'h1A5, 12'h000);

    // Asynchronous reset in the middle of Q3.
    clk_phase();
    clk_phase();
    #3;
    rst        = 1'b1;
    fetchState = 2'b10;
    #1;
    expect_val("async_rst_pc",   16'h01FF);
    expect_val("async_rst_addr", 16'h01FF);
    expect_val("async_rst_inst", 16'h0000);
    check(16'(pcOut));
    check(16'(romAddr));
    check(16'(instOut));
    @(negedge clk);
    rst = 1'b0;

    expect_val("refetch_inst", 16'h0A05);
    clk_phase();
    clk_phase();
    check(16'(instOut));
    icycle("post_rst_wrap", S_NONE, 9'h000, 12'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
